// File: rtl/fir4_par6_if.sv
// Parallel-output FIR bus: sample/coefficient inputs and the six-wide output group.
// FIR_SERIAL_OUT_EN adds the serial y_k / y_k_vld taps.
interface fir4_par6_if #(
  parameter int unsigned w_in  = 5,
  parameter int unsigned c_in  = 3,
  parameter int unsigned y_out = 12
);
  logic signed [w_in-1:0]  x_in;
  logic signed [c_in-1:0]  c_0, c_1, c_2, c_3;
  logic signed [y_out-1:0] y_6k, y_6k_1, y_6k_2, y_6k_3, y_6k_4, y_6k_5;
  logic                    valid;
`ifdef FIR_SERIAL_OUT_EN
  logic signed [y_out-1:0] y_k;
  logic                    y_k_vld;

  modport master (
    output x_in, c_0, c_1, c_2, c_3,
    input  y_6k, y_6k_1, y_6k_2, y_6k_3, y_6k_4, y_6k_5, valid, y_k, y_k_vld
  );
  modport slave (
    input  x_in, c_0, c_1, c_2, c_3,
    output y_6k, y_6k_1, y_6k_2, y_6k_3, y_6k_4, y_6k_5, valid, y_k, y_k_vld
  );
`else
  modport master (
    output x_in, c_0, c_1, c_2, c_3,
    input  y_6k, y_6k_1, y_6k_2, y_6k_3, y_6k_4, y_6k_5, valid
  );
  modport slave (
    input  x_in, c_0, c_1, c_2, c_3,
    output y_6k, y_6k_1, y_6k_2, y_6k_3, y_6k_4, y_6k_5, valid
  );
`endif
endinterface

// File: rtl/fir4_par6.sv
// Four-tap signed FIR, one sample per clk, collected into groups of six parallel outputs.
// Optional macro FIR_SERIAL_OUT_EN exposes the internal y_k / y_k_vld registers.
module fir4_par6 #(
  parameter int unsigned w_in  = 5,
  parameter int unsigned c_in  = 3,
  parameter int unsigned y_out = 12
) (
  input logic        clk,
  input logic        rstn,
  fir4_par6_if.slave bus
);

  localparam int unsigned prod_w = w_in + c_in;

  logic signed [w_in-1:0]   d0, d1, d2;
  logic signed [prod_w-1:0] p0, p1, p2, p3;
  logic signed [y_out-1:0]  y_k, y_k_d;
  logic                     y_k_vld;
  logic [2:0]               cnt;
  logic signed [y_out-1:0]  b     [5];
  logic signed [y_out-1:0]  y_par [6];
  logic                     valid;

  // Operands widened to the full product width so the multiply is exact.
  always_comb begin
    p0    = prod_w'(bus.x_in) * prod_w'(bus.c_0);
    p1    = prod_w'(d0) * prod_w'(bus.c_1);
    p2    = prod_w'(d1) * prod_w'(bus.c_2);
    p3    = prod_w'(d2) * prod_w'(bus.c_3);
    y_k_d = y_out'(p0) + y_out'(p1) + y_out'(p2) + y_out'(p3);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d0      <= '0;
      d1      <= '0;
      d2      <= '0;
      y_k     <= '0;
      y_k_vld <= 1'b0;
      cnt     <= '0;
      valid   <= 1'b0;
      for (int i = 0; i < 5; i++) b[i] <= '0;
      for (int i = 0; i < 6; i++) y_par[i] <= '0;
    end else begin
      d0      <= bus.x_in;
      d1      <= d0;
      d2      <= d1;
      y_k     <= y_k_d;
      y_k_vld <= 1'b1;
      valid   <= 1'b0;
      if (y_k_vld) begin
        if (cnt == 3'd5) begin
          // Sixth sample goes straight to the newest output, skipping the buffer.
          for (int i = 0; i < 5; i++) y_par[i] <= b[i];
          y_par[5] <= y_k;
          cnt      <= '0;
          valid    <= 1'b1;
        end else begin
          b[cnt] <= y_k;
          cnt    <= cnt + 3'd1;
        end
      end
    end
  end

  assign bus.y_6k   = y_par[0];
  assign bus.y_6k_1 = y_par[1];
  assign bus.y_6k_2 = y_par[2];
  assign bus.y_6k_3 = y_par[3];
  assign bus.y_6k_4 = y_par[4];
  assign bus.y_6k_5 = y_par[5];
  assign bus.valid  = valid;
`ifdef FIR_SERIAL_OUT_EN
  assign bus.y_k     = y_k;
  assign bus.y_k_vld = y_k_vld;
`endif

endmodule

// File: tb/tb_fir4_par6.sv
// Directed bench for fir4_par6: reset, impulse, constant, extremes, cadence against a
// software convolution, and mid-group reset.
module tb_fir4_par6;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   ca [4];
  int   xs [0:610];

  fir4_par6_if #(.w_in(5), .c_in(3), .y_out(12)) bus ();

  fir4_par6 #(.w_in(5), .c_in(3), .y_out(12)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int par_out(input int i);
    case (i)
      0:       return int'(bus.y_6k);
      1:       return int'(bus.y_6k_1);
      2:       return int'(bus.y_6k_2);
      3:       return int'(bus.y_6k_3);
      4:       return int'(bus.y_6k_4);
      default: return int'(bus.y_6k_5);
    endcase
  endfunction

  task automatic check_group(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int e5);
    check({tag, ".valid"}, int'(bus.valid), 1);
    check({tag, ".y0"}, par_out(0), e0);
    check({tag, ".y1"}, par_out(1), e1);
    check({tag, ".y2"}, par_out(2), e2);
    check({tag, ".y3"}, par_out(3), e3);
    check({tag, ".y4"}, par_out(4), e4);
    check({tag, ".y5"}, par_out(5), e5);
  endtask

  task automatic tick(input int x);
    bus.x_in = 5'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input int a, input int b, input int c, input int d);
    ca[0] = a; ca[1] = b; ca[2] = c; ca[3] = d;
    bus.c_0 = 3'(a);
    bus.c_1 = 3'(b);
    bus.c_2 = 3'(c);
    bus.c_3 = 3'(d);
  endtask

  // Leaves rstn released #1 after a posedge, so the next posedge is E1.
  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) begin
      bus.x_in = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
  endtask

  function automatic int conv(input int n);
    int s;
    s = 0;
    for (int j = 0; j < 4; j++) if (n - j >= 1) s += ca[j] * xs[n - j];
    return s;
  endfunction

  initial begin
    int loads;
    int prev_valid;
    int g;
    checks = 0;
    errors = 0;
    rstn = 1'b1;
    bus.x_in = '0;
    set_c(-1, -1, -2, 3);
    @(posedge clk);
    #1;

    // Reset holds everything at zero regardless of x_in.
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.x_in = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      check("rst.valid", int'(bus.valid), 0);
      check("rst.y0", par_out(0), 0);
      check("rst.y5", par_out(5), 0);
    end
    rstn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick($urandom_range(0, 14));
      check("pre_e7.valid", int'(bus.valid), 0);
      check("pre_e7.y5", par_out(5), 0);
    end

    // Impulse.
    do_reset();
    tick(1);
    for (int k = 2; k <= 6; k++) tick(0);
    check("imp.e6.valid", int'(bus.valid), 0);
    tick(0);
    check_group("imp.g1", -1, -1, -2, 3, 0, 0);
    for (int k = 8; k <= 12; k++) begin
      tick(0);
      check("imp.hold.valid", int'(bus.valid), 0);
      check("imp.hold.y3", par_out(3), 3);
    end
    tick(0);
    check_group("imp.g2", 0, 0, 0, 0, 0, 0);

    // Constant input.
    do_reset();
    for (int k = 1; k <= 7; k++) tick(14);
    check_group("const.g1", -14, -28, -56, -14, -14, -14);
    for (int k = 8; k <= 13; k++) tick(14);
    check_group("const.g2", -14, -14, -14, -14, -14, -14);

    // Extremes: no wrap at the widest products.
    set_c(-4, -4, -4, -4);
    do_reset();
    for (int k = 1; k <= 7; k++) tick(-16);
    check_group("ext_neg.g1", 64, 128, 192, 256, 256, 256);
    for (int k = 8; k <= 13; k++) tick(-16);
    check_group("ext_neg.g2", 256, 256, 256, 256, 256, 256);
    do_reset();
    for (int k = 1; k <= 13; k++) tick(15);
    check_group("ext_pos.g2", -240, -240, -240, -240, -240, -240);

    // Cadence and random data against a software convolution.
    set_c(3, -4, 2, -1);
    do_reset();
    xs[0] = 0;
    loads = 0;
    prev_valid = 0;
    for (int k = 1; k <= 601; k++) begin
      xs[k] = $urandom_range(0, 14);
      tick(xs[k]);
      if (bus.valid) begin
        loads++;
        check("cad.consecutive", prev_valid, 0);
        check("cad.edge", (k - 1) % 6, 0);
        g = (k - 1) / 6;
        for (int i = 0; i < 6; i++) check("cad.y", par_out(i), conv(6 * (g - 1) + 1 + i));
      end
      prev_valid = int'(bus.valid);
    end
    check("cad.loads", loads, 100);

    // Mid-group reset at cnt=3.
    set_c(-1, -1, -2, 3);
    do_reset();
    for (int k = 1; k <= 7; k++) tick(7);
    check_group("mid.g1", -7, -14, -28, -7, -7, -7);
    for (int k = 8; k <= 10; k++) tick(7);
    rstn = 1'b0;
    #1;
    check("mid.rst.y0", par_out(0), 0);
    check("mid.rst.y5", par_out(5), 0);
    check("mid.rst.valid", int'(bus.valid), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick(2);
    for (int k = 2; k <= 6; k++) begin
      tick(0);
      check("mid.pre.valid", int'(bus.valid), 0);
    end
    tick(0);
    check_group("mid.g1_post", -2, -2, -4, 6, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
